// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: size encodings,
// FSM state type and the byte-lane helper functions.
package lsu_pkg;

   localparam int LSU_XLEN = 32;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } lsu_state_e;

   // Byte enables for an access of the given size at byte offset off.
   function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] off);
      logic [3:0] be;
      case (funct3)
         LSU_B, LSU_BU: be = 4'b0001 << off;
         LSU_H, LSU_HU: be = 4'b0011 << off;
         default:       be = 4'hF;
      endcase
      return be;
   endfunction

   // Access is not naturally aligned for its size.
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic bad;
      case (funct3)
         LSU_B, LSU_BU: bad = 1'b0;
         LSU_H, LSU_HU: bad = off[0];
         default:       bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

   // Replicate store data across every lane so the byte enables pick the right one.
   function automatic logic [LSU_XLEN-1:0] lsu_wdata(input logic [2:0] funct3,
                                                      input logic [LSU_XLEN-1:0] d);
      logic [LSU_XLEN-1:0] w;
      case (funct3)
         LSU_B, LSU_BU: w = {4{d[7:0]}};
         LSU_H, LSU_HU: w = {2{d[15:0]}};
         default:       w = d;
      endcase
      return w;
   endfunction

   // Sign- or zero-extend right-justified load data according to size/sign.
   function automatic logic [LSU_XLEN-1:0] lsu_extend(input logic [LSU_XLEN-1:0] d,
                                                       input logic [2:0] funct3);
      logic [LSU_XLEN-1:0] r;
      case (funct3)
         LSU_B:   r = {{(LSU_XLEN-8){d[7]}}, d[7:0]};
         LSU_H:   r = {{(LSU_XLEN-16){d[15]}}, d[15:0]};
         LSU_BU:  r = {{(LSU_XLEN-8){1'b0}}, d[7:0]};
         LSU_HU:  r = {{(LSU_XLEN-16){1'b0}}, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shift the addressed lane down to bit 0, then
// extend to full width. Also used by the fetch alignment path.
module load_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] shifted;

   assign shifted = rdata >> {off, 3'b000};
   assign data    = XLEN'(lsu_extend(LSU_XLEN'(shifted), funct3));

endmodule

// File: rtl/stage_memory_lsu.sv
// Memory pipeline stage. Non-memory results pass straight through with one
// cycle of latency; loads/stores issue one bus request and stall until ack.
module stage_memory_lsu
   import lsu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ADDR_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  execute_valid,
   input  logic [REG_ADDR_W-1:0] execute_rd,
   input  logic [XLEN-1:0]       execute_alu_result,
   input  logic [XLEN-1:0]       execute_store_data,
   input  logic                  execute_mem_read,
   input  logic                  execute_mem_write,
   input  logic [2:0]            execute_funct3,
   input  logic                  execute_mem_to_reg,
   input  logic                  execute_wr_enable,
   input  logic                  flush,
   output logic                  stall,
   output logic                  dbus_req,
   output logic                  dbus_we,
   output logic [ADDR_W-1:0]     dbus_addr,
   output logic [XLEN-1:0]       dbus_wdata,
   output logic [XLEN/8-1:0]     dbus_be,
   input  logic                  dbus_ack,
   input  logic [XLEN-1:0]       dbus_rdata,
   output logic                  mem_valid,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [XLEN-1:0]       mem_result,
   output logic                  mem_wr_enable,
   output logic                  mem_mem_to_reg,
   output logic                  mem_misaligned
);

   localparam int BE_W = XLEN / 8;

   lsu_state_e            state;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       res_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic                  load_q;
   logic                  wr_en_q;
   logic                  m2r_q;
   logic                  flushed_q;

   logic                  mem_op;
   logic                  misal;
   logic                  start;
   logic [XLEN-1:0]       load_data;

   assign mem_op = execute_mem_read | execute_mem_write;
   assign misal  = lsu_misaligned(execute_funct3, execute_alu_result[1:0]);
   assign start  = (state == S_IDLE) && execute_valid && mem_op && !misal && !flush;

   // Stall while an aligned access is being captured and during every unacked wait cycle.
   assign stall = !rst && (start || (state == S_WAIT && !dbus_ack));

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata  (dbus_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .data   (load_data)
   );

   // Stage FSM: capture, bus handshake and registered writeback outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         mem_valid      <= 1'b0;
         mem_rd         <= '0;
         mem_result     <= '0;
         mem_wr_enable  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_misaligned <= 1'b0;
         dbus_req       <= 1'b0;
         dbus_we        <= 1'b0;
         dbus_addr      <= '0;
         dbus_wdata     <= '0;
         dbus_be        <= '0;
         rd_q           <= '0;
         res_q          <= '0;
         f3_q           <= '0;
         off_q          <= '0;
         load_q         <= 1'b0;
         wr_en_q        <= 1'b0;
         m2r_q          <= 1'b0;
         flushed_q      <= 1'b0;
      end else begin
         mem_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (execute_valid && !flush) begin
                  if (!mem_op) begin
                     mem_valid      <= 1'b1;
                     mem_rd         <= execute_rd;
                     mem_result     <= execute_alu_result;
                     mem_wr_enable  <= execute_wr_enable;
                     mem_mem_to_reg <= execute_mem_to_reg;
                     mem_misaligned <= 1'b0;
                  end else if (misal) begin
                     // Faulting access: report it without touching the bus.
                     mem_valid      <= 1'b1;
                     mem_rd         <= execute_rd;
                     mem_result     <= execute_alu_result;
                     mem_wr_enable  <= 1'b0;
                     mem_mem_to_reg <= execute_mem_to_reg;
                     mem_misaligned <= 1'b1;
                  end else begin
                     state      <= S_WAIT;
                     dbus_req   <= 1'b1;
                     dbus_we    <= execute_mem_write;
                     dbus_addr  <= {execute_alu_result[ADDR_W-1:2], 2'b00};
                     dbus_be    <= BE_W'(lsu_be(execute_funct3, execute_alu_result[1:0]));
                     dbus_wdata <= XLEN'(lsu_wdata(execute_funct3, LSU_XLEN'(execute_store_data)));
                     rd_q       <= execute_rd;
                     res_q      <= execute_alu_result;
                     f3_q       <= execute_funct3;
                     off_q      <= execute_alu_result[1:0];
                     load_q     <= execute_mem_read;
                     wr_en_q    <= execute_wr_enable;
                     m2r_q      <= execute_mem_to_reg;
                     flushed_q  <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               // The bus cannot abort, so a flush only suppresses the writeback.
               if (dbus_ack) begin
                  state    <= S_IDLE;
                  dbus_req <= 1'b0;
                  if (!(flushed_q || flush)) begin
                     mem_valid      <= 1'b1;
                     mem_rd         <= rd_q;
                     mem_result     <= load_q ? load_data : res_q;
                     mem_wr_enable  <= load_q & wr_en_q;
                     mem_mem_to_reg <= m2r_q;
                     mem_misaligned <= 1'b0;
                  end
               end else if (flush) begin
                  flushed_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_memory_lsu.sv
// Directed bench for stage_memory_lsu with hand-computed expected values.
module tb_stage_memory_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        execute_valid;
   logic [4:0]  execute_rd;
   logic [31:0] execute_alu_result;
   logic [31:0] execute_store_data;
   logic        execute_mem_read;
   logic        execute_mem_write;
   logic [2:0]  execute_funct3;
   logic        execute_mem_to_reg;
   logic        execute_wr_enable;
   logic        flush;
   logic        stall;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        mem_wr_enable;
   logic        mem_mem_to_reg;
   logic        mem_misaligned;

   int n_chk  = 0;
   int n_fail = 0;
   int stall_total = 0;
   int s0;

   always #5 clk = ~clk;

   stage_memory_lsu dut (
      .clk                (clk),
      .rst                (rst),
      .execute_valid      (execute_valid),
      .execute_rd         (execute_rd),
      .execute_alu_result (execute_alu_result),
      .execute_store_data (execute_store_data),
      .execute_mem_read   (execute_mem_read),
      .execute_mem_write  (execute_mem_write),
      .execute_funct3     (execute_funct3),
      .execute_mem_to_reg (execute_mem_to_reg),
      .execute_wr_enable  (execute_wr_enable),
      .flush              (flush),
      .stall              (stall),
      .dbus_req           (dbus_req),
      .dbus_we            (dbus_we),
      .dbus_addr          (dbus_addr),
      .dbus_wdata         (dbus_wdata),
      .dbus_be            (dbus_be),
      .dbus_ack           (dbus_ack),
      .dbus_rdata         (dbus_rdata),
      .mem_valid          (mem_valid),
      .mem_rd             (mem_rd),
      .mem_result         (mem_result),
      .mem_wr_enable      (mem_wr_enable),
      .mem_mem_to_reg     (mem_mem_to_reg),
      .mem_misaligned     (mem_misaligned)
   );

   // Running count of stalled cycles, sampled mid-cycle.
   always @(negedge clk) if (stall) stall_total = stall_total + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      execute_valid      = 1'b0;
      execute_rd         = '0;
      execute_alu_result = '0;
      execute_store_data = '0;
      execute_mem_read   = 1'b0;
      execute_mem_write  = 1'b0;
      execute_funct3     = 3'b010;
      execute_mem_to_reg = 1'b0;
      execute_wr_enable  = 1'b0;
   endtask

   task automatic op(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                     input logic rdm, input logic wrm, input logic [2:0] f3,
                     input logic m2r, input logic we);
      execute_valid      = 1'b1;
      execute_rd         = rd;
      execute_alu_result = alu;
      execute_store_data = sd;
      execute_mem_read   = rdm;
      execute_mem_write  = wrm;
      execute_funct3     = f3;
      execute_mem_to_reg = m2r;
      execute_wr_enable  = we;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
      idle_in();
      cyc(); cyc();
      chk("rst_valid", {31'd0, mem_valid}, 0);
      chk("rst_result", mem_result, 0);
      chk("rst_req", {31'd0, dbus_req}, 0);
      chk("rst_be", {28'd0, dbus_be}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      rst = 1'b0;

      // ALU pass-through
      s0 = stall_total;
      op(5'd7, 32'h1234_5678, 0, 0, 0, 3'b010, 0, 1);
      cyc(); idle_in();
      chk("alu_valid", {31'd0, mem_valid}, 1);
      chk("alu_result", mem_result, 32'h1234_5678);
      chk("alu_rd", {27'd0, mem_rd}, 7);
      chk("alu_wen", {31'd0, mem_wr_enable}, 1);
      cyc();
      chk("alu_valid_drop", {31'd0, mem_valid}, 0);
      chk("alu_stalls", stall_total - s0, 0);

      // LB at 0x103, ack on first request cycle
      s0 = stall_total;
      op(5'd3, 32'h0000_0103, 0, 1, 0, 3'b000, 1, 1);
      #1 chk("lb_stall_cap", {31'd0, stall}, 1);
      cyc(); idle_in();
      dbus_ack = 1'b1; dbus_rdata = 32'h80FF_FF7F;
      #1;
      chk("lb_req", {31'd0, dbus_req}, 1);
      chk("lb_addr", dbus_addr, 32'h100);
      chk("lb_be", {28'd0, dbus_be}, 4'b1000);
      chk("lb_we", {31'd0, dbus_we}, 0);
      chk("lb_stall_ack", {31'd0, stall}, 0);
      cyc(); dbus_ack = 1'b0;
      chk("lb_valid", {31'd0, mem_valid}, 1);
      chk("lb_result", mem_result, 32'hFFFF_FF80);
      chk("lb_wen", {31'd0, mem_wr_enable}, 1);
      chk("lb_req_drop", {31'd0, dbus_req}, 0);
      chk("lb_stalls", stall_total - s0, 1);

      // SH 0xABCD1234 at 0x202, ack after 3 wait cycles
      s0 = stall_total;
      op(5'd4, 32'h0000_0202, 32'hABCD_1234, 0, 1, 3'b001, 0, 1);
      cyc(); idle_in();
      for (int i = 0; i < 3; i++) begin
         chk("sh_req", {31'd0, dbus_req}, 1);
         cyc();
      end
      chk("sh_be", {28'd0, dbus_be}, 4'b1100);
      chk("sh_wdata", dbus_wdata, 32'h1234_1234);
      chk("sh_we", {31'd0, dbus_we}, 1);
      chk("sh_addr", dbus_addr, 32'h200);
      dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      cyc(); dbus_ack = 1'b0;
      chk("sh_valid", {31'd0, mem_valid}, 1);
      chk("sh_wen", {31'd0, mem_wr_enable}, 0);
      chk("sh_stalls", stall_total - s0, 4);

      // LH at offset 2, sign extension of upper half
      op(5'd5, 32'h0000_0602, 0, 1, 0, 3'b001, 1, 1);
      cyc(); idle_in();
      dbus_ack = 1'b1; dbus_rdata = 32'h8001_0000;
      chk("lh_be", {28'd0, dbus_be}, 4'b1100);
      cyc(); dbus_ack = 1'b0;
      chk("lh_result", mem_result, 32'hFFFF_8001);

      // SB at offset 1 with immediate ack
      op(5'd6, 32'h0000_0701, 32'h0000_00A5, 0, 1, 3'b000, 0, 0);
      cyc(); idle_in();
      dbus_ack = 1'b1;
      chk("sb_be", {28'd0, dbus_be}, 4'b0010);
      chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
      cyc(); dbus_ack = 1'b0;

      // LW at 0x301 is misaligned: no bus traffic, no stall
      s0 = stall_total;
      op(5'd8, 32'h0000_0301, 0, 1, 0, 3'b010, 1, 1);
      #1 chk("lw_mis_stall", {31'd0, stall}, 0);
      cyc(); idle_in();
      chk("lw_mis_valid", {31'd0, mem_valid}, 1);
      chk("lw_mis_flag", {31'd0, mem_misaligned}, 1);
      chk("lw_mis_wen", {31'd0, mem_wr_enable}, 0);
      chk("lw_mis_req", {31'd0, dbus_req}, 0);
      chk("lw_mis_stalls", stall_total - s0, 0);

      // LHU at 0x400 flushed during WAIT, ack two cycles later
      op(5'd10, 32'h0000_0400, 0, 1, 0, 3'b101, 1, 1);
      cyc(); idle_in();
      flush = 1'b1;
      #1 chk("fl_stall", {31'd0, stall}, 1);
      cyc(); flush = 1'b0;
      chk("fl_req_hold", {31'd0, dbus_req}, 1);
      chk("fl_valid0", {31'd0, mem_valid}, 0);
      dbus_ack = 1'b1; dbus_rdata = 32'h0000_BEEF;
      cyc(); dbus_ack = 1'b0;
      chk("fl_valid_ack", {31'd0, mem_valid}, 0);
      chk("fl_req_drop", {31'd0, dbus_req}, 0);
      chk("fl_result_hold", mem_result, 32'h0000_0301);

      // Flush in IDLE drops an ALU op
      op(5'd11, 32'h0000_00AA, 0, 0, 0, 3'b010, 0, 1);
      flush = 1'b1;
      cyc(); idle_in(); flush = 1'b0;
      chk("fl_idle_valid", {31'd0, mem_valid}, 0);

      // Reset in the middle of a store wait
      op(5'd12, 32'h0000_0500, 32'hDEAD_BEEF, 0, 1, 3'b010, 0, 0);
      cyc(); idle_in();
      chk("rw_req", {31'd0, dbus_req}, 1);
      rst = 1'b1;
      cyc(); rst = 1'b0;
      chk("rw_req0", {31'd0, dbus_req}, 0);
      chk("rw_valid0", {31'd0, mem_valid}, 0);
      chk("rw_result0", mem_result, 0);
      chk("rw_be0", {28'd0, dbus_be}, 0);
      chk("rw_addr0", dbus_addr, 0);
      #1 chk("rw_stall0", {31'd0, stall}, 0);
      op(5'd9, 32'h0000_55AA, 0, 0, 0, 3'b010, 0, 1);
      cyc(); idle_in();
      chk("rw_alu_valid", {31'd0, mem_valid}, 1);
      chk("rw_alu_result", mem_result, 32'h0000_55AA);
      chk("rw_alu_rd", {27'd0, mem_rd}, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard stop in case the run ever wedges.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stage_memory_lsu.md
# stage_memory_lsu

Parametrised memory pipeline stage with an integrated load/store unit. Sits between the execute and writeback stages. Non-memory results pass through in one cycle. Loads and stores issue a single request on a valid/ack data bus and stall the pipeline until the bus acknowledges. Byte and halfword accesses are supported, with lane steering, sign/zero extension and misalignment detection.

## Interface
Parameters:
- XLEN, 32, datapath width (32 only for now; 64 is reserved and needs doubleword support)
- REG_ADDR_W, 5, register index width
- ADDR_W, 32, data bus address width (≤ XLEN)

Ports:
- clk  in  1  clock; everything is synchronous to its rising edge
- rst  in  1  reset; synchronous, active-high
- execute_valid  in  1  execute stage presents an instruction
- execute_rd  in  REG_ADDR_W  destination register
- execute_alu_result  in  XLEN  ALU result; effective address for memory ops
- execute_store_data  in  XLEN  rs2 value for stores
- execute_mem_read  in  1  load
- execute_mem_write  in  1  store
- execute_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- execute_mem_to_reg  in  1  writeback selects memory data
- execute_wr_enable  in  1  register write enable
- flush  in  1  discard the captured or pending instruction
- stall  out  1  hold execute and earlier stages
- dbus_req  out  1  bus request
- dbus_we  out  1  write request
- dbus_addr  out  ADDR_W  word-aligned address
- dbus_wdata  out  XLEN  lane-steered store data
- dbus_be  out  XLEN/8  byte enables
- dbus_ack  in  1  request completed; rdata valid this cycle
- dbus_rdata  in  XLEN  read data
- mem_valid  out  1  writeback stage input is valid
- mem_rd  out  REG_ADDR_W
- mem_result  out  XLEN  ALU result, or extended load data
- mem_wr_enable  out  1
- mem_mem_to_reg  out  1
- mem_misaligned  out  1  access fault flag, valid with mem_valid

## Operation
- FSM states are IDLE and WAIT.
- In IDLE, with execute_valid and neither mem_read nor mem_write: register the instruction into the mem_* outputs. mem_result = execute_alu_result. Stall stays low.
- In IDLE, with a memory op:
  - Misaligned access (H with addr[0] set, W with addr[1:0] ≠ 0): no bus request. Register mem_misaligned = 1, mem_wr_enable = 0, mem_valid = 1.
  - Aligned access: capture addr, we, be, wdata, rd, funct3, addr[1:0] and control bits; go to WAIT. Stall is high combinationally in this cycle and in every WAIT cycle without ack.
- Byte enables: B → 4'b0001 << addr[1:0]; H → 4'b0011 << addr[1:0]; W → 4'hF.
- Store data lane replication: B → {4{d[7:0]}}; H → {2{d[15:0]}}.
- In WAIT, dbus_req = 1. addr, we, be and wdata stay stable until ack.
- On dbus_ack in WAIT:
  - Load: mem_result = rdata shifted right by 8·addr[1:0], then sign- or zero-extended per funct3.
  - Store: mem_wr_enable is forced to 0.
  - mem_valid = 1; return to IDLE; stall is low in the ack cycle.
- A cycle in which mem_valid is not registered high drives mem_valid = 0. Other mem_* fields hold their values.
- flush in IDLE: nothing is captured and mem_valid = 0 next cycle.
- flush in WAIT: the request stays asserted until ack (the bus cannot abort). The ack then completes with mem_valid = 0; a flushed load never writes back. Stall stays asserted until that ack.
- dbus_ack outside WAIT is ignored.

## Timing
- Non-memory op: 1-cycle latency, execute → mem_*.
- Memory op: earliest dbus_req is the cycle after capture. Ack in that same cycle gives 2-cycle total latency and 1 stall cycle. Each further ack wait adds one stall cycle.
- Reset values: state IDLE; mem_valid 0; mem_rd 0; mem_result 0; mem_wr_enable 0; mem_mem_to_reg 0; mem_misaligned 0; dbus_req 0; dbus_we 0; dbus_addr 0; dbus_wdata 0; dbus_be 0; stall 0.
- Reset during WAIT returns to IDLE immediately and drops dbus_req the next cycle. The interconnect is reset with the same signal.
- rst has priority over flush; flush has priority over capture.

## Structure
- Shared package `lsu_pkg`: funct3 size encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state enum `lsu_state_e`, and functions `lsu_be()` and `lsu_extend()`.
- One sub-module `load_align`: combinational rdata shift plus extension, parametrised on XLEN. It is reused by a later instruction-fetch alignment path.

## Test plan
- ALU op, rd = 7, result 0x1234_5678 → mem_valid = 1, mem_result = 0x1234_5678 on the next edge; stall never high.
- LB at 0x103, rdata 0x80FF_FF7F, ack on the first req cycle → be = 4'b1000, addr = 0x100, mem_result = 0xFFFF_FF80; exactly 1 stall cycle.
- SH 0xABCD_1234 at 0x202, ack after 3 wait cycles → be = 4'b1100, wdata = 0x1234_1234, we = 1, mem_wr_enable = 0; 4 stall cycles.
- LW at 0x301 → no dbus_req, mem_misaligned = 1, mem_wr_enable = 0, stall never high.
- LHU at 0x400 with flush during WAIT, ack 2 cycles later → req held until ack, mem_valid stays 0.
- rst asserted mid-WAIT → dbus_req = 0 and all outputs at reset values the next cycle; a following ALU op completes normally.
